ram_sdp_be: RTL
===============

RAM_SDP_BE -- requirements
Module: ram_sdp_be

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_BUS_WIDTH, default 4: width of both address buses.
REQ-003 Parameter MAX_MEM_LOC, default 15: highest valid address; depth = MAX_MEM_LOC+1, at most 2**ADDR_BUS_WIDTH.
REQ-004 Parameter RD_LATENCY, default 1: read latency in clocks; legal values 1 or 2.
REQ-005 Parameter RDW_MODE, default 0: same-address read-during-write result; 0 = old data, 1 = new data.
REQ-006 Parameter CLEAR_ON_RESET, default 1: 1 = zero the whole array after reset.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 write_en  input  1  write request.
REQ-010 wr_addr  input  ADDR_BUS_WIDTH  write address.
REQ-011 data_inbit  input  DATA_WIDTH  write data.
REQ-012 byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i enables data_inbit[8i+7:8i].
REQ-013 read_en  input  1  read request.
REQ-014 rd_addr  input  ADDR_BUS_WIDTH  read address.
REQ-015 data_outbit  output  DATA_WIDTH  read data; never driven to Z.
REQ-016 rd_valid  output  1  one-cycle strobe qualifying data_outbit.
REQ-017 init_busy  output  1  high while the array is being cleared; requests are ignored while it is high.
REQ-018 addr_err  output  1  one-cycle strobe flagging an out-of-range request.

Function
REQ-019 Reads and writes SHALL be independent and may be issued on the same edge, every cycle.
REQ-020 A write sampled at edge k SHALL update only the enabled bytes; all other bytes are unchanged; byte_en = 0 is a no-op.
REQ-021 A read sampled at edge k SHALL present data_outbit with rd_valid = 1 after edge k+RD_LATENCY-1; back-to-back reads SHALL be fully pipelined.
REQ-022 When rd_valid = 0, data_outbit SHALL hold its last value.
REQ-023 Same-address read and write on one edge: RDW_MODE 0 SHALL return the pre-write word; RDW_MODE 1 SHALL return the merged word (enabled bytes new, other bytes old).
REQ-024 An address above MAX_MEM_LOC SHALL suppress the write.
REQ-025 An out-of-range read SHALL return 0 with rd_valid = 1.
REQ-026 addr_err SHALL pulse in the cycle after an out-of-range request on either port.
REQ-027 Clear FSM states SHALL be CLEAR and READY; CLEAR writes 0 to address 0..MAX_MEM_LOC, one address per cycle, then moves to READY.
REQ-028 In CLEAR, read_en and write_en SHALL be ignored: no write, no rd_valid, no addr_err.
REQ-029 With CLEAR_ON_RESET = 0, the FSM SHALL go directly to READY and array contents are undefined until written.

Reset
REQ-030 While rst is high at an edge: data_outbit = 0, rd_valid = 0, addr_err = 0, read pipeline flushed, clear counter = 0.
REQ-031 While rst is high, the FSM SHALL be in CLEAR (CLEAR_ON_RESET = 1, so init_busy = 1) or READY (CLEAR_ON_RESET = 0).
REQ-032 With CLEAR_ON_RESET = 1, init_busy SHALL fall exactly MAX_MEM_LOC+1 cycles after rst deasserts.
REQ-033 rst asserted mid-clear SHALL restart clearing at address 0.
REQ-034 rst asserted with reads in flight SHALL discard them; no rd_valid is produced for those reads.
REQ-035 Array contents SHALL NOT be reset except through the CLEAR state.

Structure
REQ-036 A shared package ram_pkg SHALL hold the RDW_MODE encodings, the FSM state enum and the default parameter constants; the bench shall use the same package.
REQ-037 A single sub-module ram_rd_pipe SHALL implement the RD_LATENCY-stage output register with its valid bit and flush.
REQ-038 Elaboration SHALL fail for RD_LATENCY not in {1,2}, for DATA_WIDTH not a multiple of 8, or for MAX_MEM_LOC >= 2**ADDR_BUS_WIDTH.

Verification
REQ-039 Defaults: rst for 2 cycles -> init_busy high for 16 cycles after release; then a read of each address 0..15 returns 0x00.
REQ-040 Write 0xA5 to addr 3 with byte_en = 1, then read addr 3 -> data_outbit = 0xA5 with rd_valid one cycle after the read edge; repeat with RD_LATENCY = 2 -> two cycles.
REQ-041 DATA_WIDTH = 32: write 0x11223344 to addr 5, then 0xFFFFFFFF with byte_en = 0101 -> read returns 0x11FF33FF.
REQ-042 Same-edge read/write of 0x5A to addr 7 (old value 0x00) -> RDW_MODE 0 returns 0x00; RDW_MODE 1 returns 0x5A.
REQ-043 MAX_MEM_LOC = 9: write to addr 12 -> addr_err pulses and no array change; read addr 12 -> data_outbit = 0, rd_valid = 1, addr_err = 1.
REQ-044 rst asserted at clear count 6, with reads issued during CLEAR -> clearing restarts at 0, no rd_valid during CLEAR, init_busy falls 16 cycles after release.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable simple dual-port RAM: read-during-write
// encodings, clear FSM states, default parameter values and an index-width helper.
package ram_pkg;

  localparam int RDW_OLD_DATA = 0;
  localparam int RDW_NEW_DATA = 1;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_BUS_WIDTH = 4;
  localparam int DEF_MAX_MEM_LOC    = 15;
  localparam int DEF_RD_LATENCY     = 1;
  localparam int DEF_RDW_MODE       = RDW_OLD_DATA;
  localparam int DEF_CLEAR_ON_RESET = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read output pipeline: RD_LATENCY register stages carrying the read word and its
// valid bit. The last stage only loads on a valid word so the output holds between
// reads, and reset flushes every stage so in-flight reads never surface.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  outValid_d;
  logic [DATA_WIDTH-1:0] outData_d;
  logic                  outValid_q;
  logic [DATA_WIDTH-1:0] outData_q;

  if (RD_LATENCY == 2) begin : g_two_stage
    logic                  stageValid_q;
    logic [DATA_WIDTH-1:0] stageData_q;

    // Extra stage in front of the output register for the two-cycle latency.
    always_ff @(posedge clk) begin
      if (rst) begin
        stageValid_q <= 1'b0;
        stageData_q  <= '0;
      end else begin
        stageValid_q <= valid_i;
        if (valid_i) begin
          stageData_q <= data_i;
        end
      end
    end

    assign outValid_d = stageValid_q;
    assign outData_d  = stageData_q;
  end else begin : g_one_stage
    assign outValid_d = valid_i;
    assign outData_d  = data_i;
  end

  // Output register: valid is a one-cycle strobe, data holds until the next valid word.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      outValid_q <= outValid_d;
      if (outValid_d) begin
        outData_q <= outData_d;
      end
    end
  end

  assign valid_o = outValid_q;
  assign data_o  = outData_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with per-byte write enables, selectable read latency and
// read-during-write behaviour, range checking on both ports, and an optional
// post-reset clear sequence that zeroes one location per cycle.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_BUS_WIDTH = DEF_ADDR_BUS_WIDTH,
  parameter int MAX_MEM_LOC    = DEF_MAX_MEM_LOC,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int RDW_MODE       = DEF_RDW_MODE,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [ADDR_BUS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     data_inbit,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
  input  logic                      read_en,
  input  logic [ADDR_BUS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     data_outbit,
  output logic                      rd_valid,
  output logic                      init_busy,
  output logic                      addr_err
);

  localparam int          NUM_BYTES = DATA_WIDTH / 8;
  localparam int          IDX_W     = idxWidth(MAX_MEM_LOC + 1);
  localparam int unsigned LAST_LOC  = MAX_MEM_LOC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_MEM_LOC);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("ram_sdp_be: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (MAX_MEM_LOC < 0 || MAX_MEM_LOC >= (2 ** ADDR_BUS_WIDTH)) begin : g_bad_depth
    $error("ram_sdp_be: MAX_MEM_LOC must lie below 2**ADDR_BUS_WIDTH");
  end
  if (RDW_MODE != RDW_OLD_DATA && RDW_MODE != RDW_NEW_DATA) begin : g_bad_rdw
    $error("ram_sdp_be: RDW_MODE must be 0 or 1");
  end

  clr_state_e             state_q;
  logic [IDX_W-1:0]       clrCnt_q;
  logic                   addrErr_q;
  logic [DATA_WIDTH-1:0]  mem [0:MAX_MEM_LOC];

  logic                   ready;
  logic                   clrWrite;
  logic                   wrInRange;
  logic                   rdInRange;
  logic                   wrAccept;
  logic                   rdAccept;
  logic                   sameAddr;
  logic                   addrErr_d;
  logic [IDX_W-1:0]       wrIdx;
  logic [IDX_W-1:0]       rdIdx;
  logic [DATA_WIDTH-1:0]  byteMask;
  logic [DATA_WIDTH-1:0]  oldWord;
  logic [DATA_WIDTH-1:0]  mergedWord;
  logic [DATA_WIDTH-1:0]  rdWord_d;

  // Request qualification and the read word, including the same-address bypass.
  always_comb begin
    ready      = (state_q == READY) && !rst;
    clrWrite   = (state_q == CLEAR) && !rst;
    wrInRange  = 32'(wr_addr) <= LAST_LOC;
    rdInRange  = 32'(rd_addr) <= LAST_LOC;
    wrAccept   = ready && write_en && wrInRange;
    rdAccept   = ready && read_en;
    sameAddr   = wrAccept && rdInRange && (wr_addr == rd_addr);
    addrErr_d  = ready && ((write_en && !wrInRange) || (read_en && !rdInRange));
    wrIdx      = wr_addr[IDX_W-1:0];
    rdIdx      = rd_addr[IDX_W-1:0];
    byteMask   = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      byteMask[8*b +: 8] = {8{byte_en[b]}};
    end
    oldWord    = rdInRange ? mem[rdIdx] : '0;
    mergedWord = (oldWord & ~byteMask) | (data_inbit & byteMask);
    rdWord_d   = oldWord;
    if (RDW_MODE == RDW_NEW_DATA && sameAddr) begin
      rdWord_d = mergedWord;
    end
  end

  // Storage array: the clear sequence owns the write port until READY, then byte writes.
  always_ff @(posedge clk) begin
    if (clrWrite) begin
      mem[clrCnt_q] <= '0;
    end else if (wrAccept) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byte_en[b]) begin
          mem[wrIdx][8*b +: 8] <= data_inbit[8*b +: 8];
        end
      end
    end
  end

  // Clear FSM: walks the counter over every location once, then parks in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= CLEAR;
      end else begin
        state_q <= READY;
      end
      clrCnt_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clrCnt_q == LAST_IDX) begin
            state_q  <= READY;
            clrCnt_q <= '0;
          end else begin
            clrCnt_q <= clrCnt_q + IDX_W'(1);
          end
        end
        READY: begin
          state_q <= READY;
        end
      endcase
    end
  end

  // Out-of-range strobe, one cycle after the offending request on either port.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrErr_q <= 1'b0;
    end else begin
      addrErr_q <= addrErr_d;
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rdAccept),
    .data_i  (rdWord_d),
    .valid_o (rd_valid),
    .data_o  (data_outbit)
  );

  assign init_busy = (state_q == CLEAR);
  assign addr_err  = addrErr_q;

endmodule
